// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned MAX_INPUTS = 8;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between bus masters and the arbiter.
// The timeout signal exists only when BUS_ARBITER_TIMEOUT_EN is defined.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned INPUTS = 2
);
  localparam int unsigned IW = idx_width(INPUTS);

  logic [INPUTS-1:0] request;
  logic [INPUTS-1:0] grant;
  logic [IW-1:0]     grantIndex;
  logic              busy;
`ifdef BUS_ARBITER_TIMEOUT_EN
  logic              timeout;
`endif

  modport slave (
    input  request,
`ifdef BUS_ARBITER_TIMEOUT_EN
    output timeout,
`endif
    output grant, grantIndex, busy
  );

  modport master (
    output request,
`ifdef BUS_ARBITER_TIMEOUT_EN
    input  timeout,
`endif
    input  grant, grantIndex, busy
  );

endinterface

// File: rtl/rotating_priority_encoder.sv
// Combinational search for the first eligible bit starting at pointer, wrapping modulo INPUTS.
module rotating_priority_encoder
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned INPUTS = 2,
  localparam int unsigned IW = idx_width(INPUTS)
) (
  input  logic [INPUTS-1:0] eligible,
  input  logic [IW-1:0]     pointer,
  output logic [INPUTS-1:0] winner,
  output logic [IW-1:0]     index,
  output logic              valid
);

  int unsigned   idx;
  logic [IW-1:0] sel;

  always_comb begin
    winner = '0;
    index  = '0;
    valid  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int unsigned k = 0; k < INPUTS; k++) begin
      idx = (32'(pointer) + k) % INPUTS;
      sel = IW'(idx);
      if (!valid && eligible[sel]) begin
        valid       = 1'b1;
        winner[sel] = 1'b1;
        index       = sel;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter with held grants for the shared peripheral bus.
// Optional forced release after TIMEOUT_CYCLES when BUS_ARBITER_TIMEOUT_EN is defined.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned INPUTS         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bus
);

  localparam int unsigned IW = idx_width(INPUTS);

  if (INPUTS < 2 || INPUTS > MAX_INPUTS) begin : g_bad_inputs
    $error("bus_arbiter: INPUTS out of range");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES out of range");
  end

  arb_state_e        state_q, state_d;
  logic [INPUTS-1:0] grant_q, grant_d;
  logic [IW-1:0]     index_q, index_d;
  logic [IW-1:0]     pointer_q, pointer_d;
  logic [INPUTS-1:0] eligible_c, win_c;
  logic [IW-1:0]     win_idx_c;
  logic              win_valid_c, holder_req_c, take_c, drop_c;

  // The current holder is never eligible, so a re-raised request is not continuation.
`ifdef BUS_ARBITER_TIMEOUT_EN
  logic [INPUTS-1:0] mask_q, mask_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  assign eligible_c = bus.request & ~grant_q & ~mask_q;
`else
  assign eligible_c = bus.request & ~grant_q;
`endif

  assign holder_req_c = |(bus.request & grant_q);

  rotating_priority_encoder #(.INPUTS(INPUTS)) u_enc (
    .eligible (eligible_c),
    .pointer  (pointer_q),
    .winner   (win_c),
    .index    (win_idx_c),
    .valid    (win_valid_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      index_q   <= '0;
      pointer_q <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      mask_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      index_q   <= index_d;
      pointer_q <= pointer_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    index_d   = index_q;
    pointer_d = pointer_q;
    take_c    = 1'b0;
    drop_c    = 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
    mask_d    = mask_q & bus.request;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        take_c = win_valid_c;
      end
      ARB_GRANTED: begin
        if (!holder_req_c) begin
          take_c = win_valid_c;
          drop_c = !win_valid_c;
        end
`ifdef BUS_ARBITER_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          mask_d    = mask_d | grant_q;
          take_c    = win_valid_c;
          drop_c    = !win_valid_c;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: drop_c = 1'b1;
    endcase

    if (take_c) begin
      state_d   = ARB_GRANTED;
      grant_d   = win_c;
      index_d   = win_idx_c;
      pointer_d = (win_idx_c == IW'(INPUTS - 1)) ? '0 : win_idx_c + IW'(1);
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_d     = '0;
`endif
    end else if (drop_c) begin
      state_d = ARB_IDLE;
      grant_d = '0;
      index_d = '0;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grantIndex = index_q;
  assign bus.busy       = (state_q == ARB_GRANTED);
`ifdef BUS_ARBITER_TIMEOUT_EN
  assign bus.timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_bus_arbiter;

  localparam int N = 4;
  localparam int T = 8;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int HOLD_N = 6;
`else
  localparam int HOLD_N = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  bus_arbiter_if #(.INPUTS(N)) bus ();

  bus_arbiter #(.INPUTS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the bus, where the search starts, who is locked out.
  int       m_holder;
  int       m_ptr;
  int       m_cnt;
  bit [3:0] m_mask;
  bit       m_to;

  function automatic int find(input bit [3:0] elig, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (elig[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic award(input int w);
    if (w >= 0) begin
      m_holder = w;
      m_ptr    = (w + 1) % N;
      m_cnt    = 0;
    end else begin
      m_holder = -1;
    end
  endtask

  task automatic model_step(input bit [3:0] req, input bit r);
    bit [3:0] nmask;
    m_to = 1'b0;
    if (r) begin
      m_holder = -1; m_ptr = 0; m_cnt = 0; m_mask = '0;
      return;
    end
    nmask = m_mask & req;
    if (m_holder < 0) begin
      award(find(req & ~m_mask, -1));
    end else if (!req[m_holder]) begin
      award(find(req & ~m_mask, m_holder));
    end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
      if (m_cnt == T - 1) begin
        m_to = 1'b1;
        nmask[m_holder] = 1'b1;
        award(find(req & ~m_mask, m_holder));
      end else begin
        m_cnt++;
      end
`endif
    end
    m_mask = nmask;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare on the falling edge.
  task automatic cyc(input logic [3:0] req, input logic r);
    rst         = r;
    bus.request = req;
    model_step(req, r);
    @(negedge clk);
    chk("grant", 32'(bus.grant), (m_holder < 0) ? 32'd0 : 32'(1) << m_holder);
    chk("index", 32'(bus.grantIndex), (m_holder < 0) ? 32'd0 : 32'(m_holder));
    chk("busy", 32'(bus.busy), 32'(m_holder >= 0));
`ifdef BUS_ARBITER_TIMEOUT_EN
    chk("timeout", 32'(bus.timeout), 32'(m_to));
`endif
  endtask

  initial begin
    logic [3:0] rq;
    bus.request = '0;

    // Reset state
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // Single request, one-cycle latency, release
    cyc(4'b0100, 1'b0);
    chk("single_grant", 32'(bus.grant), 32'h4);
    chk("single_index", 32'(bus.grantIndex), 32'd2);
    cyc(4'b0100, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("release", 32'(bus.grant), 32'd0);

    // Wrap and skip from pointer 3
    cyc(4'b0010, 1'b0);
    chk("wrap_grant", 32'(bus.grant), 32'h2);
    chk("wrap_index", 32'(bus.grantIndex), 32'd1);
    cyc(4'b0000, 1'b0);
    cyc(4'b1111, 1'b0);
    chk("ptr_after_wrap", 32'(bus.grant), 32'h4);

    // Rotation with direct switch and no idle bubble
    cyc(4'b0000, 1'b1);
    cyc(4'b1111, 1'b0);
    chk("rot_first", 32'(bus.grant), 32'h1);
    for (int g = 0; g < 4; g++) begin
      cyc(4'b1111, 1'b0);
      cyc(4'b1111, 1'b0);
      cyc(4'b1111 & ~(4'b0001 << g), 1'b0);
      chk("rot_next", 32'(bus.grant), 32'(1) << ((g + 1) % N));
      chk("rot_busy", 32'(bus.busy), 32'd1);
      cyc(4'b1111, 1'b0);
    end

    // Hold against competing requests
    cyc(4'b0000, 1'b1);
    cyc(4'b0010, 1'b0);
    for (int i = 0; i < HOLD_N; i++) begin
      cyc(4'b1011, 1'b0);
      chk("hold", 32'(bus.grant), 32'h2);
    end

    // Reset mid-grant, then arbitration restarts at pointer 0
    cyc(4'b0000, 1'b1);
    cyc(4'b1000, 1'b0);
    cyc(4'b1000, 1'b0);
    chk("pre_rst", 32'(bus.grant), 32'h8);
    cyc(4'b1000, 1'b1);
    chk("mid_rst_grant", 32'(bus.grant), 32'd0);
    chk("mid_rst_index", 32'(bus.grantIndex), 32'd0);
    cyc(4'b1111, 1'b0);
    chk("post_rst", 32'(bus.grant), 32'h1);

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Forced release after T granted cycles, lockout until request drops
    cyc(4'b0000, 1'b1);
    cyc(4'b0001, 1'b0);
    for (int i = 0; i < T - 1; i++) begin
      cyc(4'b0011, 1'b0);
      chk("to_hold", 32'(bus.grant), 32'h1);
      chk("to_quiet", 32'(bus.timeout), 32'd0);
    end
    cyc(4'b0011, 1'b0);
    chk("to_switch", 32'(bus.grant), 32'h2);
    chk("to_pulse", 32'(bus.timeout), 32'd1);
    cyc(4'b0011, 1'b0);
    chk("to_once", 32'(bus.timeout), 32'd0);
    cyc(4'b0001, 1'b0);
    chk("to_masked", 32'(bus.grant), 32'd0);
    cyc(4'b0001, 1'b0);
    chk("to_still_masked", 32'(bus.grant), 32'd0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0001, 1'b0);
    chk("to_regrant", 32'(bus.grant), 32'h1);
`endif

    // Random sticky traffic with occasional reset
    rq = '0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      cyc(rq, ($urandom_range(49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
